// File: rtl/ifetch_wb.sv
// Wishbone classic instruction-fetch master feeding decode through a DEPTH-entry prefetch FIFO.
// Optional bus watchdog is compiled in when IFETCH_WB_TIMEOUT_EN is defined.
module ifetch_wb #(
   parameter logic [31:0] RESET_PC = 32'h0000_1000,
   parameter int          DEPTH    = 4,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic        wb_tga_o,
   output logic [1:0]  wb_sel_o,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_data_o,
   output logic [31:0] fetch_pc_o,
   input  logic        fetch_ready_i,
   output logic        bus_err_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUS  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [31:0]   data_q [DEPTH];
   logic [31:0]   addr_q [DEPTH];
   logic          in_bus, push, pop, err_w, tmo_hit;
   logic [1:0]    unused_pc_lsb;

   // A flush cycle discards both the ack and any pop.
   assign in_bus        = (state_q == S_BUS);
   assign push          = in_bus && wb_ack_i && !flush_i;
   assign pop           = (count_q != '0) && fetch_ready_i && !flush_i;
   assign unused_pc_lsb = flush_pc_i[1:0];

`ifdef IFETCH_WB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_q, err_d;

   assign tmo_hit = in_bus && !wb_ack_i && (tmo_q == TW'(TIMEOUT - 1));

   always_comb begin
      tmo_d = '0;
      err_d = err_q;
      if (flush_i)                  err_d = 1'b0;
      else if (tmo_hit)             err_d = 1'b1;
      else if (in_bus && !wb_ack_i) tmo_d = tmo_q + TW'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= tmo_d;
         err_q <= err_d;
      end
   end

   assign err_w = err_q;
`else
   // Watchdog absent: never fires, a missing ack stalls in BUS.
   assign tmo_hit = (TIMEOUT < 0);
   assign err_w   = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q + CW'(push) - CW'(pop);
      if (flush_i) begin
         state_d = S_IDLE;
         pc_d    = {flush_pc_i[31:2], 2'b00};
         count_d = '0;
      end else begin
         case (state_q)
            S_IDLE: if ((count_q < CW'(DEPTH)) && !err_w) state_d = S_BUS;
            S_BUS: begin
               if (wb_ack_i) begin
                  pc_d = pc_q + 32'd4;
                  if (count_d == CW'(DEPTH)) state_d = S_IDLE;
               end else if (tmo_hit) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) begin
               data_q[wr_ptr_q] <= wb_dat_i;
               addr_q[wr_ptr_q] <= pc_q;
               wr_ptr_q         <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   assign wb_adr_o      = pc_q;
   assign wb_cyc_o      = in_bus;
   assign wb_stb_o      = in_bus;
   assign wb_we_o       = 1'b0;
   assign wb_tga_o      = 1'b1;
   assign wb_sel_o      = 2'b11;
   assign bus_err_o     = err_w;
   assign fetch_valid_o = (count_q != '0);
   assign fetch_data_o  = data_q[rd_ptr_q];
   assign fetch_pc_o    = addr_q[rd_ptr_q];
endmodule
